// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode/funct constants, nop encoding, forward selects.
package mips_pkg;

  localparam int unsigned DW  = 32;
  localparam int unsigned RW  = 5;
  localparam int unsigned OPW = 6;
  localparam int unsigned FNW = 6;

  localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPW-1:0] OP_BNE   = 6'h05;
  localparam logic [OPW-1:0] OP_LUI   = 6'h0F;
  localparam logic [OPW-1:0] OP_LW    = 6'h23;
  localparam logic [OPW-1:0] OP_SB    = 6'h28;
  localparam logic [OPW-1:0] OP_SH    = 6'h29;
  localparam logic [OPW-1:0] OP_SW    = 6'h2B;

  localparam logic [FNW-1:0] F_SLL = 6'h00;
  localparam logic [FNW-1:0] F_SRL = 6'h02;
  localparam logic [FNW-1:0] F_SRA = 6'h03;

  // sll $0,$0,0 : all-zero opcode and ALU_control
  localparam logic [OPW-1:0] NOP_OPCODE = OP_RTYPE;
  localparam logic [FNW-1:0] NOP_FUNCT  = F_SLL;

  // Operand source select
  typedef enum logic [1:0] {
    FWD_ID  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/hazard_unit.sv
// Source-use decode, stall generation and forward-select encoding for ID->EX.
// Optional macro ID_EX_FORWARD_EN: forwarding with load-use-only stalls;
// otherwise stall on any live EX/MEM producer of a used source.
module hazard_unit
  import mips_pkg::*;
#(
  parameter int unsigned RW = 5
) (
  input  logic          id_valid,
  input  logic [5:0]    id_opcode,
  input  logic [5:0]    id_funct,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          ex_valid,
  input  logic          ex_reg_write,
  input  logic          ex_mem_read,
  input  logic [RW-1:0] ex_dest,
  input  logic          mem_reg_write,
  input  logic [RW-1:0] mem_rd,
  input  logic          flush,
  output logic          stall_c,
  output fwd_sel_e      rs_sel_c,
  output fwd_sel_e      rt_sel_c
);

  logic uses_rs, uses_rt;
  logic rs_ex_match, rt_ex_match;
  logic rs_mem_hit, rt_mem_hit;

  // Which source registers the ID instruction actually reads
  always_comb begin
    uses_rs = 1'b1;
    uses_rt = 1'b0;
    if (id_opcode == OP_RTYPE) begin
      uses_rt = 1'b1;
      if (id_funct inside {F_SLL, F_SRL, F_SRA}) uses_rs = 1'b0;
    end else if (id_opcode == OP_LUI) begin
      uses_rs = 1'b0;
    end else if (id_opcode inside {OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW}) begin
      uses_rt = 1'b1;
    end
  end

  // Source matches against EX and MEM destinations ($0 never matches)
  always_comb begin
    rs_ex_match = uses_rs && ex_valid && (ex_dest != '0) && (ex_dest == id_rs);
    rt_ex_match = uses_rt && ex_valid && (ex_dest != '0) && (ex_dest == id_rt);
    rs_mem_hit  = uses_rs && mem_reg_write && (mem_rd != '0) && (mem_rd == id_rs);
    rt_mem_hit  = uses_rt && mem_reg_write && (mem_rd != '0) && (mem_rd == id_rt);
  end

`ifdef ID_EX_FORWARD_EN
  // Load-use stall; otherwise pick the youngest producer per operand
  always_comb begin
    stall_c  = id_valid && !flush && ex_mem_read && (rs_ex_match || rt_ex_match);
    rs_sel_c = FWD_ID;
    rt_sel_c = FWD_ID;
    if (rs_ex_match && ex_reg_write && !ex_mem_read) rs_sel_c = FWD_EX;
    else if (rs_mem_hit)                             rs_sel_c = FWD_MEM;
    if (rt_ex_match && ex_reg_write && !ex_mem_read) rt_sel_c = FWD_EX;
    else if (rt_mem_hit)                             rt_sel_c = FWD_MEM;
  end
`else
  logic unused_mem_read;
  assign unused_mem_read = ex_mem_read;

  // Hold ID until every producer of a used source has reached WB
  always_comb begin
    stall_c  = id_valid && !flush &&
               ((ex_reg_write && (rs_ex_match || rt_ex_match)) || rs_mem_hit || rt_mem_hit);
    rs_sel_c = FWD_ID;
    rt_sel_c = FWD_ID;
  end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the 32-bit ALU, with hazard resolution.
// Optional macro ID_EX_FORWARD_EN enables capture-time forwarding.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [5:0]    id_opcode,
  input  logic [5:0]    id_funct,
  input  logic [4:0]    id_shamt,
  input  logic [15:0]   id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic [DW-1:0] alu_result,
  input  logic          mem_reg_write,
  input  logic [RW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  input  logic          flush,
  output logic          ex_valid,
  output logic [5:0]    ex_opcode,
  output logic [5:0]    ex_alu_control,
  output logic [4:0]    ex_shamt,
  output logic [15:0]   ex_immediate,
  output logic [DW-1:0] ex_rs_content,
  output logic [DW-1:0] ex_rt_content,
  output logic [RW-1:0] ex_dest,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          stall_id
);

  fwd_sel_e      rs_sel_c, rt_sel_c;
  logic [DW-1:0] rs_op_c, rt_op_c;
  logic [RW-1:0] id_dest_c;
  logic          bubble_c;

  hazard_unit #(.RW(RW)) u_hazard (
    .id_valid      (id_valid),
    .id_opcode     (id_opcode),
    .id_funct      (id_funct),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_dest       (ex_dest),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .flush         (flush),
    .stall_c       (stall_id),
    .rs_sel_c      (rs_sel_c),
    .rt_sel_c      (rt_sel_c)
  );

  // Destination field and bubble decision
  always_comb begin
    id_dest_c = (id_opcode == OP_RTYPE) ? id_rd : id_rt;
    bubble_c  = flush || stall_id || !id_valid;
  end

`ifdef ID_EX_FORWARD_EN
  // Operand forwarding muxes
  always_comb begin
    rs_op_c = id_rs_data;
    rt_op_c = id_rt_data;
    case (rs_sel_c)
      FWD_EX:  rs_op_c = alu_result;
      FWD_MEM: rs_op_c = mem_data;
      default: rs_op_c = id_rs_data;
    endcase
    case (rt_sel_c)
      FWD_EX:  rt_op_c = alu_result;
      FWD_MEM: rt_op_c = mem_data;
      default: rt_op_c = id_rt_data;
    endcase
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{alu_result, mem_data, 2'(rs_sel_c), 2'(rt_sel_c)};

  // Operands always come straight from the register file
  always_comb begin
    rs_op_c = id_rs_data;
    rt_op_c = id_rt_data;
  end
`endif

  // Pipeline register: capture, bubble (data held) or reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid       <= 1'b0;
      ex_opcode      <= NOP_OPCODE;
      ex_alu_control <= NOP_FUNCT;
      ex_shamt       <= '0;
      ex_immediate   <= '0;
      ex_rs_content  <= '0;
      ex_rt_content  <= '0;
      ex_dest        <= '0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
    end else if (bubble_c) begin
      ex_valid       <= 1'b0;
      ex_opcode      <= NOP_OPCODE;
      ex_alu_control <= NOP_FUNCT;
      ex_dest        <= '0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
    end else begin
      ex_valid       <= 1'b1;
      ex_opcode      <= id_opcode;
      ex_alu_control <= id_funct;
      ex_shamt       <= id_shamt;
      ex_immediate   <= id_imm;
      ex_rs_content  <= rs_op_c;
      ex_rt_content  <= rt_op_c;
      ex_dest        <= id_dest_c;
      ex_reg_write   <= id_reg_write;
      ex_mem_read    <= id_mem_read;
    end
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode and the 32-bit ALU in the MIPS core.
- Latches the decoded instruction fields and register operands, resolves RAW hazards, and presents stable ALU inputs (opcode, ALU_control, rs/rt content, shamt, immediate) for one EX cycle.
- Resolves hazards by capture-time forwarding or stall/bubble insertion.
- Consumes ALU_result for forwarding and the branch decision for flush.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- id_valid  input  1  decode holds a valid instruction.
- id_opcode  input  6  instruction[31:26].
- id_funct  input  6  instruction[5:0]; becomes ALU_control.
- id_shamt  input  5  shift amount.
- id_imm  input  16  immediate.
- id_rs, id_rt, id_rd  input  5 each  register indices.
- id_rs_data, id_rt_data  input  32 each  register-file read data.
- id_reg_write  input  1  instruction writes a register.
- id_mem_read  input  1  instruction is a load.
- alu_result  input  32  ALU output for the instruction currently held in EX.
- mem_reg_write  input  1  MEM-stage instruction writes a register.
- mem_rd  input  5  MEM-stage destination.
- mem_data  input  32  MEM-stage result (load data or ALU result).
- flush  input  1  taken branch/jump; kill EX-bound instruction.
- ex_valid  output  1  EX holds a real instruction.
- ex_opcode  output  6  to ALU opcode.
- ex_alu_control  output  6  to ALU ALU_control.
- ex_shamt  output  5  to ALU shamt.
- ex_immediate  output  16  to ALU immediate.
- ex_rs_content, ex_rt_content  output  32 each  to ALU operands.
- ex_dest  output  5  destination register.
- ex_reg_write  output  1  EX instruction writes a register.
- ex_mem_read  output  1  EX instruction is a load.
- stall_id  output  1  hold PC and IF/ID this cycle (combinational).

Behaviour:
- Reset: all outputs and registers 0. ex_opcode=0 with ex_alu_control=0 encodes the nop sll $0.
- Destination: dest = id_rd if id_opcode==0, else id_rt. id_reg_write with dest==0 is treated as no write.
- Source use:
  - rs is used except for R-type funct 0x00/0x02/0x03 and opcode 0x0F (lui).
  - rt is used for R-type and for opcodes 0x04, 0x05, 0x28, 0x29, 0x2B.
  - Unused sources never cause stall or forwarding.
- The register file is write-first, so the WB stage needs no forwarding.
- Load-use hazard: ex_valid && ex_mem_read && ex_dest!=0 && ex_dest matches a used id source && id_valid → stall_id=1. The next EX entry is a bubble; the ID instruction is re-presented next cycle.
- Bubble: ex_valid, ex_reg_write, ex_mem_read, ex_opcode, ex_alu_control, ex_dest all 0. Data fields hold their previous values.
- Capture (no stall, no flush): all id_* fields register into ex_* with 1-cycle latency; ex_valid=id_valid.
- Forwarding per operand, priority high→low:
  1. EX instruction: ex_valid && ex_reg_write && !ex_mem_read && ex_dest==src → alu_result.
  2. MEM instruction: mem_reg_write && mem_rd==src && src!=0 → mem_data.
  3. Otherwise id_*_data.
- Register $0 is never forwarded.
- flush=1 has priority over stall: the next entry is a bubble and stall_id=0.
- Stall with flush the same cycle: flush wins.
- Reset mid-stall: everything clears; no pending state survives.
- id_valid=0 is captured as a bubble and never stalls.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding as above; only load-use stalls (1 cycle).
- Undefined: no forwarding muxes. stall_id=1 while any used source matches a live writing destination in EX (ex_valid && ex_reg_write) or in MEM (mem_reg_write). Operands always come from id_*_data. A dependent instruction issues once the producer reaches WB: up to 2 stall cycles.

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_RTYPE, OP_BEQ, OP_BNE, OP_LUI, OP_SB, OP_SH, OP_SW, OP_LW.
  - funct constants F_SLL, F_SRL, F_SRA.
  - NOP encoding.
- One sub-module, hazard_unit: uses_rs/uses_rt decode, stall generation, forward-select encoding.
- The pipeline register and data muxes stay in id_ex_stage.

Test Plan:
- Reset → all ex_* 0, stall_id 0. Capture add $3,$1,$2 with rs_data=5, rt_data=7 → next cycle ex_alu_control=0x20, ex_rs_content=5, ex_rt_content=7, ex_dest=3.
- EX holds add →$3 with alu_result=12; ID sub $4,$3,$1 → ex_rs_content=12 (FWD_EN). Without FWD_EN → 2 stall cycles, then rs_data is used.
- EX holds lw →$5; ID add $6,$5,$5 → stall_id=1 for one cycle and a bubble. Next cycle mem_data=0xDEADBEEF is forwarded to both operands.
- Dependence on $0, with ex_dest=0 and ex_reg_write=1 → no stall, no forward; id data is used.
- flush=1 together with a load-use stall → bubble captured, stall_id=0. Reset asserted during a stall → all outputs 0 next cycle.
- sll $2,$1,4 while EX writes $0-unrelated $7 and ID rs=$7 → no stall, because sll does not use rs; ex_shamt=4.
